// File: rtl/irq_pending_ctrl_pkg.sv
// Shared definitions for the pending-interrupt grant controller:
// FSM encoding, default grant timeout and datapath widths.
package irq_pending_ctrl_pkg;

  localparam int unsigned NUM_LINES       = 8;
  localparam int unsigned IDX_W           = 3;
  localparam int unsigned TIMER_W         = 8;
  localparam int unsigned TIMEOUT_DEFAULT = 15;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

endpackage : irq_pending_ctrl_pkg

// File: rtl/irq_pending_ctrl_prio_sel8.sv
// Combinational fixed-priority selector: bit 7 wins, returns one-hot,
// binary index and an any-set flag.
module prio_sel8
  import irq_pending_ctrl_pkg::*;
(
  input  logic [NUM_LINES-1:0] in_vec,
  output logic [NUM_LINES-1:0] onehot,
  output logic [IDX_W-1:0]     idx,
  output logic                 any
);

  // Ascending scan so the highest set bit is the last one written
  always_comb begin
    onehot = 8'h00;
    idx    = 3'd0;
    any    = 1'b0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (in_vec[i]) begin
        onehot = 8'h00;
        onehot[i] = 1'b1;
        idx    = IDX_W'(i);
        any    = 1'b1;
      end else begin
        onehot = onehot;
      end
    end
  end

endmodule : prio_sel8

// File: rtl/irq_pending_ctrl.sv
// Sticky pending-request collector that grants the highest-priority
// eligible line, waits for ack and abandons the grant after TIMEOUT cycles.
module irq_pending_ctrl
  import irq_pending_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_LINES-1:0] req,
  input  logic [NUM_LINES-1:0] mask,
  input  logic                 ack,
  input  logic                 clr_err,
  output logic [NUM_LINES-1:0] grant,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 grant_valid,
  output logic [NUM_LINES-1:0] pending,
  output logic                 timeout_err
);

  localparam logic [TIMER_W-1:0] TIMEOUT_M1 = TIMER_W'(TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [NUM_LINES-1:0] pending_q, pending_d;
  logic [NUM_LINES-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]     grant_idx_q, grant_idx_d;
  logic                 grant_valid_q, grant_valid_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 timeout_err_q, timeout_err_d;

  logic [NUM_LINES-1:0] eligible_s;
  logic [NUM_LINES-1:0] sel_onehot_s;
  logic [IDX_W-1:0]     sel_idx_s;
  logic                 sel_any_s;
  logic [NUM_LINES-1:0] clr_s;
  logic                 timeout_s;

  assign eligible_s = pending_q & mask;

  prio_sel8 u_prio_sel8 (
    .in_vec (eligible_s),
    .onehot (sel_onehot_s),
    .idx    (sel_idx_s),
    .any    (sel_any_s)
  );

  // Next-state, grant and sticky flag computation
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;
    timer_d       = timer_q;
    clr_s         = 8'h00;
    timeout_s     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (sel_any_s) begin
          state_d       = ST_GRANT;
          grant_d       = sel_onehot_s;
          grant_idx_d   = sel_idx_s;
          grant_valid_d = 1'b1;
          timer_d       = 8'd0;
        end else begin
          state_d       = ST_IDLE;
          grant_d       = 8'h00;
          grant_idx_d   = 3'd0;
          grant_valid_d = 1'b0;
          timer_d       = 8'd0;
        end
      end
      ST_GRANT: begin
        // Ack takes precedence over a timeout landing on the same edge
        if (ack) begin
          clr_s         = grant_q;
          state_d       = ST_IDLE;
          grant_d       = 8'h00;
          grant_idx_d   = 3'd0;
          grant_valid_d = 1'b0;
          timer_d       = 8'd0;
        end else if (timer_q == TIMEOUT_M1) begin
          clr_s         = grant_q;
          timeout_s     = 1'b1;
          state_d       = ST_IDLE;
          grant_d       = 8'h00;
          grant_idx_d   = 3'd0;
          grant_valid_d = 1'b0;
          timer_d       = 8'd0;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      default: begin
        state_d       = ST_IDLE;
        grant_d       = 8'h00;
        grant_idx_d   = 3'd0;
        grant_valid_d = 1'b0;
        timer_d       = 8'd0;
      end
    endcase

    // New requests win over a clear of the same bit
    pending_d = (pending_q & ~clr_s) | req;

    if (timeout_s) begin
      timeout_err_d = 1'b1;
    end else if (clr_err) begin
      timeout_err_d = 1'b0;
    end else begin
      timeout_err_d = timeout_err_q;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pending_q     <= 8'h00;
      grant_q       <= 8'h00;
      grant_idx_q   <= 3'd0;
      grant_valid_q <= 1'b0;
      timer_q       <= 8'd0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      grant_q       <= grant_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
      timer_q       <= timer_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = grant_idx_q;
  assign grant_valid = grant_valid_q;
  assign pending     = pending_q;
  assign timeout_err = timeout_err_q;

endmodule : irq_pending_ctrl

// File: tb/tb_irq_pending_ctrl.sv
// Randomized and directed bench for irq_pending_ctrl against a cycle-level
// behavioural model of pending lines, current grant and error flag.
module tb_irq_pending_ctrl;

  localparam int TO = 4;

  logic       clk;
  logic       reset;
  logic [7:0] req;
  logic [7:0] mask;
  logic       ack;
  logic       clr_err;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic [7:0] pending;
  logic       timeout_err;

  int n_total;
  int n_bad;

  // Reference model state
  bit [7:0] m_pend;
  bit       m_busy;
  int       m_line;
  int       m_cycles;
  bit       m_err;

  irq_pending_ctrl #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .mask        (mask),
    .ack         (ack),
    .clr_err     (clr_err),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .pending     (pending),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock edge of the specified behaviour
  task automatic model_step(input bit [7:0] r, input bit [7:0] m, input bit a, input bit c,
                            input bit rs);
    bit [7:0] clr;
    bit       tout;
    bit       found;
    clr  = 8'h00;
    tout = 1'b0;
    if (rs) begin
      m_pend = 8'h00; m_busy = 1'b0; m_line = 0; m_cycles = 0; m_err = 1'b0;
    end else begin
      if (m_busy) begin
        if (a) begin
          clr[m_line] = 1'b1;
          m_busy = 1'b0;
        end else if (m_cycles == TO) begin
          clr[m_line] = 1'b1;
          tout = 1'b1;
          m_busy = 1'b0;
        end else begin
          m_cycles++;
        end
      end else begin
        found = 1'b0;
        for (int i = 7; i >= 0; i--) begin
          if (!found && m_pend[i] && m[i]) begin
            found = 1'b1; m_line = i; m_busy = 1'b1; m_cycles = 1;
          end
        end
      end
      if (tout) m_err = 1'b1;
      else if (c) m_err = 1'b0;
      m_pend = (m_pend & ~clr) | r;
    end
  endtask

  task automatic cyc(input logic [7:0] r, input logic [7:0] m, input logic a, input logic c,
                     input logic rs);
    bit [7:0] one;
    bit [7:0] exp_grant;
    @(negedge clk);
    req = r; mask = m; ack = a; clr_err = c; reset = rs;
    model_step(r, m, a, c, rs);
    @(posedge clk);
    #1;
    one = 8'h01;
    exp_grant = m_busy ? (one << m_line) : 8'h00;
    check_val("grant", 32'(grant), 32'(exp_grant));
    check_val("grant_idx", 32'(grant_idx), m_busy ? 32'(m_line) : 32'd0);
    check_val("grant_valid", 32'(grant_valid), 32'(m_busy));
    check_val("pending", 32'(pending), 32'(m_pend));
    check_val("timeout_err", 32'(timeout_err), 32'(m_err));
  endtask

  initial begin
    n_total = 0; n_bad = 0;
    req = 8'h00; mask = 8'h00; ack = 1'b0; clr_err = 1'b0; reset = 1'b1;
    m_pend = 8'h00; m_busy = 1'b0; m_line = 0; m_cycles = 0; m_err = 1'b0;

    // Reset state, with requests held high to show reset dominates
    cyc(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1);
    cyc(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1);
    check_val("rst_pending", 32'(pending), 32'h0);

    // Two requests, highest granted first, then the lower one after one idle cycle
    cyc(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
    cyc(8'h24, 8'hFF, 1'b0, 1'b0, 1'b0);
    check_val("d29_pending", 32'(pending), 32'h24);
    cyc(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
    check_val("d29_grant", 32'(grant), 32'h20);
    check_val("d29_idx", 32'(grant_idx), 32'd5);
    cyc(8'h00, 8'hFF, 1'b1, 1'b0, 1'b0);
    check_val("d30_pending", 32'(pending), 32'h04);
    check_val("d30_idle", 32'(grant_valid), 32'd0);
    cyc(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
    check_val("d30_grant", 32'(grant), 32'h04);
    check_val("d30_idx", 32'(grant_idx), 32'd2);
    cyc(8'h00, 8'hFF, 1'b1, 1'b0, 1'b0);

    // Mask restricts the choice; widening it mid-grant changes nothing
    cyc(8'h81, 8'h01, 1'b0, 1'b0, 1'b0);
    cyc(8'h00, 8'h01, 1'b0, 1'b0, 1'b0);
    check_val("d31_grant", 32'(grant), 32'h01);
    cyc(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
    check_val("d31_hold", 32'(grant), 32'h01);
    cyc(8'h00, 8'hFF, 1'b1, 1'b0, 1'b0);
    cyc(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
    check_val("d31_next", 32'(grant), 32'h80);
    cyc(8'h00, 8'hFF, 1'b1, 1'b0, 1'b0);

    // Timeout after TO grant cycles, then clearing the flag
    cyc(8'h08, 8'hFF, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < TO; i++) cyc(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
    check_val("d32_last", 32'(grant), 32'h08);
    cyc(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
    check_val("d32_grant", 32'(grant), 32'h00);
    check_val("d32_err", 32'(timeout_err), 32'd1);
    check_val("d32_pend", 32'(pending), 32'h00);
    cyc(8'h00, 8'hFF, 1'b0, 1'b1, 1'b0);
    check_val("d32_clr", 32'(timeout_err), 32'd0);

    // Ack on the timeout edge is a normal ack
    cyc(8'h02, 8'hFF, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < TO; i++) cyc(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
    cyc(8'h00, 8'hFF, 1'b1, 1'b0, 1'b0);
    check_val("ack_vs_to", 32'(timeout_err), 32'd0);

    // Re-request on the ack edge keeps the bit pending and re-grants it
    cyc(8'h10, 8'hFF, 1'b0, 1'b0, 1'b0);
    cyc(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
    cyc(8'h10, 8'hFF, 1'b1, 1'b0, 1'b0);
    check_val("d33_pend", 32'(pending), 32'h10);
    cyc(8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
    check_val("d33_regrant", 32'(grant), 32'h10);

    // Reset during a grant
    cyc(8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1);
    check_val("d34_valid", 32'(grant_valid), 32'd0);
    check_val("d34_err", 32'(timeout_err), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] r;
      logic [7:0] m;
      r = 8'($urandom & $urandom & $urandom);
      m = 8'($urandom | $urandom);
      cyc(r, m, ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 99) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule : tb_irq_pending_ctrl

// File: doc/irq_pending_ctrl.md
IRQ_PENDING_CTRL -- requirements
Module: irq_pending_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, max cycles in GRANT awaiting ack (legal 1..255).
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req  input  8  level request lines, bit 7 highest priority.
REQ-005 SHALL have port mask  input  8  per-line enable, 1 = eligible for grant.
REQ-006 SHALL have port ack  input  1  consumer acknowledge of current grant.
REQ-007 SHALL have port clr_err  input  1  clears timeout_err.
REQ-008 SHALL have port grant  output  8  registered one-hot grant, zero when not granting.
REQ-009 SHALL have port grant_idx  output  3  binary index of grant bit, 0 when not granting.
REQ-010 SHALL have port grant_valid  output  1  high while in GRANT state.
REQ-011 SHALL have port pending  output  8  registered sticky pending requests.
REQ-012 SHALL have port timeout_err  output  1  sticky flag, grant abandoned by timeout.

Function
REQ-013 SHALL set pending[i] at a rising edge where req[i]=1; bit stays set until cleared per REQ-017/REQ-018.
REQ-014 SHALL use FSM states IDLE and GRANT only.
REQ-015 In IDLE, if (pending & mask) != 0 SHALL enter GRANT next edge, loading grant with one-hot of highest set bit of (pending & mask), grant_idx with its index, timer with 0.
REQ-016 In IDLE with (pending & mask) == 0 SHALL remain in IDLE; ack ignored in IDLE.
REQ-017 In GRANT with ack=1 SHALL clear the granted pending bit, zero grant/grant_idx, return to IDLE next edge.
REQ-018 In GRANT without ack SHALL increment timer; when timer reaches TIMEOUT-1 without ack SHALL clear granted pending bit, set timeout_err, zero grant, return to IDLE.
REQ-019 ack on the same cycle as timeout SHALL be treated as ack (no error).
REQ-020 Grant, grant_idx SHALL stay constant throughout GRANT regardless of req, mask, or pending changes.
REQ-021 req[i]=1 on the same edge its pending bit is cleared SHALL leave pending[i]=1 (set wins).
REQ-022 Latency: req high at edge k -> pending at k -> grant_valid at k+1; minimum one IDLE cycle between consecutive grants.
REQ-023 clr_err=1 SHALL clear timeout_err next edge; simultaneous new timeout SHALL win (flag stays 1).
REQ-024 Timer SHALL be 8 bits, never wraps within legal TIMEOUT range.

Reset
REQ-025 reset=1 at an edge SHALL force IDLE, pending=0, grant=0, grant_idx=0, grant_valid=0, timeout_err=0, timer=0, overriding all other inputs including req.
REQ-026 Reset asserted mid-GRANT SHALL abandon the grant without setting timeout_err.

Structure
REQ-027 Shared package SHALL hold FSM state encoding (IDLE=0, GRANT=1) and the default TIMEOUT constant.
REQ-028 Highest-priority one-hot selection and index encoding SHALL be a combinational sub-module prio_sel8 (in 8, out onehot 8, out idx 3, out any 1).

Verification
REQ-029 req=8'h00 then req=8'h24, mask=8'hFF one cycle -> pending=8'h24, next cycle grant=8'h20, grant_idx=5, grant_valid=1.
REQ-030 Continue REQ-029, ack=1 one cycle -> pending=8'h04, IDLE one cycle, then grant=8'h04, grant_idx=2.
REQ-031 pending=8'h81, mask=8'h01 -> grant=8'h01; mask change to 8'hFF during GRANT -> grant unchanged until ack.
REQ-032 TIMEOUT=4, grant held, no ack -> after 4 GRANT cycles grant=0, timeout_err=1, bit cleared; clr_err=1 -> timeout_err=0.
REQ-033 grant=8'h10 with ack=1 and req=8'h10 same cycle -> pending[4] remains 1, bit re-granted after one IDLE cycle.
REQ-034 reset=1 mid-GRANT with req=8'hFF -> all outputs 0 next edge, timeout_err=0.
